mux_rr_arb: RTL and testbench
=============================

// Module: mux_rr_arb
// PURPOSE
//   Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake.
//   Two modes: SEL (fixed select via sel port, as in the 4:1 mux) and RR (round-robin
//   arbitration over channels asserting valid). Output is registered, so latency is one cycle.
//   Sits between multiple producers (datapath lanes) and a single shared consumer.
// PARAMETERS
//   N     32             data width per channel
//   CH    4              number of input channels, >= 2
//   SELW  $clog2(CH)     select/index width (derived, do not override)
// PORTS
//   clk        in   1         clock; all state updates on rising edge
//   rst        in   1         asynchronous, active-high reset
//   mode       in   1         0 = SEL mode, 1 = RR mode
//   sel        in   SELW      channel select in SEL mode; ignored in RR mode
//   di         in   CH*N      packed inputs; channel k = di[k*N +: N]
//   di_valid   in   CH        per-channel valid
//   di_ready   out  CH        per-channel ready, one-hot or zero
//   dout       out  N         registered output data
//   dout_valid out  1         output register holds a beat
//   dout_ready in   1         consumer accepts beat when dout_valid && dout_ready
//   dout_ch    out  SELW      index of the channel that sourced dout
// BEHAVIOUR
//   Reset (async, asserted): dout=0, dout_valid=0, dout_ch=0, rr_ptr=0; di_ready=0 while rst=1.
//   load = !dout_valid || dout_ready. Output register accepts a new beat only when load=1.
//   Grant g is combinational from the current inputs and state:
//     SEL: g = sel; a grant exists only when di_valid[sel]=1. Other channels are never granted.
//     RR: g = first k with di_valid[k]=1, searching rr_ptr, rr_ptr+1, ..., CH-1, 0, ..., rr_ptr-1.
//   di_ready[g] = load && grant exists; all other di_ready bits = 0. Never more than one bit set.
//   Transfer on channel g when di_valid[g] && di_ready[g]. On the next edge:
//     dout <= di[g], dout_ch <= g, dout_valid <= 1.
//   When load=1 and there is no transfer: dout_valid <= 0. dout and dout_ch hold their old values.
//   When dout_valid && !dout_ready: dout, dout_ch and dout_valid hold. Every di_ready bit = 0.
//   rr_ptr updates only on a transfer in RR mode: rr_ptr <= (g==CH-1) ? 0 : g+1.
//   In SEL mode rr_ptr is frozen.
//   Back-to-back: with dout_ready=1 held, one beat per cycle; full throughput with no bubbles.
//   mode/sel may change on any cycle and take effect combinationally that same cycle.
//   A beat already held in dout is unaffected by a mode or sel change.
//   sel >= CH (non-power-of-two CH): no grant. This is not an error.
//   All di_valid=0: no grant, and rr_ptr is unchanged.
//   A single requester in RR mode is granted every cycle. No starvation: any continuously
//   valid channel is granted within CH transfers.
//   rst asserted mid-burst: the held beat is dropped, all state returns to reset values
//   immediately, and no di_ready is asserted until the first edge after rst deasserts.
// STRUCTURE
//   Package mux_rr_arb_pkg:
//     localparams MODE_SEL=1'b0, MODE_RR=1'b1;
//     function next_ptr(idx, CH) implementing the wrap-around increment.
//   Sub-module rr_pick #(CH): purely combinational rotating-priority search.
//     Inputs: req[CH], ptr[SELW]. Outputs: gnt_idx[SELW], gnt_any.
//     Implemented as a doubled request vector with a priority encoder.
//   Top level holds the output register, rr_ptr, the mode mux of grants, and the ready decode.
// TESTING
//   1 Reset: rst=1 mid-traffic -> dout_valid=0, dout=0, dout_ch=0, di_ready=0 asynchronously.
//   2 SEL mode, CH=4, N=32, sel=2, di_valid=4'b1111, di[2]=32'hCAFE_0002, dout_ready=1
//     -> next cycle dout=32'hCAFE_0002, dout_ch=2, di_ready=4'b0100 each cycle.
//   3 RR mode, all four valid, dout_ready=1 for 8 cycles
//     -> dout_ch sequence 0,1,2,3,0,1,2,3; di_ready rotates 0001,0010,0100,1000.
//   4 RR mode, di_valid=4'b1010, rr_ptr=0 -> grants 1,3,1,3.
//     Then drop ch3 -> grants 1,1 (rr_ptr=2 each time).
//   5 Backpressure: beat held with dout_ready=0 for 3 cycles -> dout/dout_ch stable,
//     di_ready=0, rr_ptr unchanged. Release -> next beat on the following edge, no bubble.
//   6 Mode switch RR->SEL with sel=3 while rr_ptr=1 -> only ch3 granted.
//     Switch back -> RR resumes from rr_ptr=1.

Source files
------------

// File: rtl/mux_rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arb_pkg
// Description : Shared constants and helpers for the registered N-channel
//               mux / round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_rr_arb_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Wrap-around increment of a channel index: the last channel wraps to 0.
  function automatic int next_ptr(input int idx, input int ch);
    return (idx == ch - 1) ? 0 : idx + 1;
  endfunction

endpackage : mux_rr_arb_pkg
`default_nettype wire

// File: rtl/mux_rr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority search. Finds the first set
//               request starting at ptr and wrapping past CH-1 back to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int CH   = 4,
  parameter int SELW = $clog2(CH)
) (
  input  logic [CH-1:0]   req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  // Doubling the request vector turns the wrap-around search into a plain
  // shift followed by a lowest-bit-first priority encoder.
  logic [2*CH-1:0] w_dbl;
  logic [CH-1:0]   w_rot;

  assign w_dbl = {req, req};
  assign w_rot = CH'(w_dbl >> ptr);

  // Priority encode the rotated vector; descending loop lets the lowest
  // offset from ptr win, then the offset is mapped back to a channel index.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        gnt_any = 1'b1;
        gnt_idx = (int'(ptr) + i >= CH) ? SELW'(int'(ptr) + i - CH)
                                        : SELW'(int'(ptr) + i);
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arb
// Description : Registered CH-to-1 multiplexer with valid/ready handshake.
//               Fixed-select (SEL) or round-robin (RR) channel choice; one
//               cycle latency, full throughput when the consumer is ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arb
  import mux_rr_arb_pkg::*;
#(
  parameter int N    = 32,
  parameter int CH   = 4,
  parameter int SELW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [CH*N-1:0] di,
  input  logic [CH-1:0]   di_valid,
  output logic [CH-1:0]   di_ready,
  output logic [N-1:0]    dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [SELW-1:0] dout_ch
);

  logic [N-1:0]    r_dout;
  logic            r_dout_valid;
  logic [SELW-1:0] r_dout_ch;
  logic [SELW-1:0] r_rr_ptr;
  logic            r_armed;     // low from reset until the first edge after it

  logic [SELW-1:0] w_rr_idx;
  logic            w_rr_any;
  logic            w_sel_any;
  logic [SELW-1:0] w_g;
  logic            w_gnt_any;
  logic            w_load;
  logic            w_xfer;

  rr_pick #(
    .CH   (CH),
    .SELW (SELW)
  ) u_rr_pick (
    .req     (di_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_rr_idx),
    .gnt_any (w_rr_any)
  );

  // SEL-mode grant exists only when sel names a real channel that is valid;
  // an out-of-range sel simply matches nothing.
  always_comb begin
    w_sel_any = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if ((sel == SELW'(k)) && di_valid[k]) w_sel_any = 1'b1;
    end
  end

  assign w_g       = (mode == MODE_RR) ? w_rr_idx : sel;
  assign w_gnt_any = (mode == MODE_RR) ? w_rr_any : w_sel_any;
  assign w_load    = !r_dout_valid || dout_ready;
  // A grant implies di_valid[w_g], so a granted ready is always a transfer.
  assign w_xfer    = r_armed && w_load && w_gnt_any;

  for (genvar k = 0; k < CH; k++) begin : g_ready
    assign di_ready[k] = w_xfer && (w_g == SELW'(k));
  end

  // Output register, source index, round-robin pointer and post-reset arm flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_ch    <= '0;
      r_rr_ptr     <= '0;
      r_armed      <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_xfer) begin
        r_dout       <= di[w_g*N +: N];
        r_dout_ch    <= w_g;
        r_dout_valid <= 1'b1;
        if (mode == MODE_RR) r_rr_ptr <= SELW'(next_ptr(int'(w_g), CH));
      end else if (w_load) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign dout_ch    = r_dout_ch;

endmodule : mux_rr_arb
`default_nettype wire

// File: tb/tb_mux_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arb
// Description : Directed self-checking bench for mux_rr_arb (CH=4, N=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arb;

  localparam int N    = 32;
  localparam int CH   = 4;
  localparam int SELW = 2;

  logic            clk;
  logic            rst;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [CH*N-1:0] di;
  logic [CH-1:0]   di_valid;
  logic [CH-1:0]   di_ready;
  logic [N-1:0]    dout;
  logic            dout_valid;
  logic            dout_ready;
  logic [SELW-1:0] dout_ch;

  int n_chk  = 0;
  int n_pass = 0;

  mux_rr_arb #(
    .N    (N),
    .CH   (CH),
    .SELW (SELW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .sel        (sel),
    .di         (di),
    .di_valid   (di_valid),
    .di_ready   (di_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_ch    (dout_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check one registered beat: data is CAFE_000k for channel k.
  task automatic chk_beat(input string tag, input int ch);
    chk({tag, "_valid"}, dout_valid, 1'b1);
    chk({tag, "_ch"}, dout_ch, ch[SELW-1:0]);
    chk({tag, "_data"}, dout, 32'hCAFE_0000 | ch);
  endtask

  int seq4 [4] = '{1, 3, 1, 3};

  initial begin
    rst        = 1'b1;
    mode       = 1'b0;
    sel        = '0;
    di         = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    di_valid   = '0;
    dout_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_dout", dout, 32'h0);
    chk("rst_ch", dout_ch, 2'd0);
    chk("rst_ready", di_ready, 4'b0000);

    // Released, valid inputs present, but no ready before first edge
    rst        = 1'b0;
    mode       = 1'b0;
    sel        = 2'd2;
    di_valid   = 4'b1111;
    dout_ready = 1'b1;
    #1;
    chk("pre_arm_ready", di_ready, 4'b0000);

    // SEL mode, sel=2
    step();
    chk("sel_ready0", di_ready, 4'b0100);
    step();
    chk_beat("sel_beat0", 2);
    chk("sel_ready1", di_ready, 4'b0100);
    step();
    chk_beat("sel_beat1", 2);

    // RR mode, all valid: 0,1,2,3,0,1,2,3 (rr_ptr frozen at 0 by SEL mode)
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #0;
      chk($sformatf("rr_all_ready%0d", i), di_ready, 4'b0001 << (i % 4));
      step();
      chk_beat($sformatf("rr_all%0d", i), i % 4);
    end

    // RR, di_valid=1010 from rr_ptr=0: 1,3,1,3
    di_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_beat($sformatf("rr_1010_%0d", i), seq4[i]);
    end
    // Drop ch3: 1,1
    di_valid = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_beat($sformatf("rr_single%0d", i), 1);
    end

    // Backpressure: hold ch1 beat three cycles, rr_ptr stays 2
    di_valid   = 4'b1111;
    dout_ready = 1'b0;
    #1;
    chk("bp_ready_now", di_ready, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_beat($sformatf("bp_hold%0d", i), 1);
      chk($sformatf("bp_ready%0d", i), di_ready, 4'b0000);
    end
    dout_ready = 1'b1;
    #1;
    chk("bp_release_ready", di_ready, 4'b0100);
    step();
    chk_beat("bp_rel0", 2);
    chk("bp_rel_ready1", di_ready, 4'b1000);
    step();
    chk_beat("bp_rel1", 3);
    step();
    chk_beat("bp_rel2", 0);              // rr_ptr now 1

    // Mode switch RR->SEL with sel=3: only ch3
    mode = 1'b0;
    sel  = 2'd3;
    #1;
    chk("ms_sel_ready", di_ready, 4'b1000);
    step();
    chk_beat("ms_sel0", 3);
    step();
    chk_beat("ms_sel1", 3);
    // Back to RR: resume from rr_ptr=1
    mode = 1'b1;
    #1;
    chk("ms_rr_ready", di_ready, 4'b0010);
    step();
    chk_beat("ms_rr0", 1);               // rr_ptr now 2

    // SEL with selected channel idle: no grant, beat drains, data holds
    mode     = 1'b0;
    sel      = 2'd3;
    di_valid = 4'b0111;
    #1;
    chk("sel_idle_ready", di_ready, 4'b0000);
    step();
    chk("sel_idle_valid", dout_valid, 1'b0);
    chk("sel_idle_ch", dout_ch, 2'd1);
    chk("sel_idle_dout", dout, 32'hCAFE_0001);

    // RR with nothing valid: rr_ptr unchanged
    mode     = 1'b1;
    di_valid = 4'b0000;
    step();
    chk("rr_none_valid", dout_valid, 1'b0);
    di_valid = 4'b1111;
    #1;
    chk("rr_none_ptr", di_ready, 4'b0100);
    step();
    chk_beat("rr_after_none", 2);

    // Asynchronous reset mid-burst, away from the clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", dout_valid, 1'b0);
    chk("mid_rst_dout", dout, 32'h0);
    chk("mid_rst_ch", dout_ch, 2'd0);
    chk("mid_rst_ready", di_ready, 4'b0000);
    step();
    chk("mid_rst_hold_ready", di_ready, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_mux_rr_arb
`default_nettype wire
